// File: rtl/lenet_pkg.sv
// -----------------------------------------------------------------------------
// lenet_pkg
// Definitions shared by the LeNet sequencing controller and its load counter:
// the controller state encoding (also exported on stat_state), the register
// byte offsets seen from the AXI4-Lite decode, the default per-image word
// counts, and the buffer address widths.
// -----------------------------------------------------------------------------
package lenet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Register byte offsets
  localparam logic [4:0] REG_CTRL   = 5'h00;  // bit0: 1 = start load, 0 = stop/ack
  localparam logic [4:0] REG_WEIGHT = 5'h04;
  localparam logic [4:0] REG_BIAS   = 5'h08;
  localparam logic [4:0] REG_FMAP   = 5'h0C;
  localparam logic [4:0] REG_DONE   = 5'h14;  // read side only
  localparam logic [4:0] REG_RESULT = 5'h18;  // read side only
  localparam logic [4:0] REG_CLEAR  = 5'h1C;  // bit0: soft clear

  // Default word counts per inference
  localparam int unsigned N_WEIGHT_DEF = 3220;
  localparam int unsigned N_BIAS_DEF   = 10;
  localparam int unsigned N_FMAP_DEF   = 784;
  localparam int unsigned DATA_W_DEF   = 32;

  // Buffer address widths
  localparam int unsigned W_ADDR_W = 12;
  localparam int unsigned B_ADDR_W = 4;
  localparam int unsigned F_ADDR_W = 10;

endpackage

// File: rtl/lenet_load_cnt.sv
// -----------------------------------------------------------------------------
// lenet_load_cnt
// Saturating word counter for one buffer stream. The count doubles as the
// buffer write address; full_o is high once LIMIT words have been accepted.
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   clr_i  : return the count to zero (wins over inc_i)
//   inc_i  : accept one word
//   cnt_o  : current count / next write address
//   full_o : count == LIMIT
// -----------------------------------------------------------------------------
module lenet_load_cnt #(
  parameter int unsigned LIMIT = 10,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             full_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign full_o = (cnt_q == CNT_W'(LIMIT));
  assign cnt_o  = cnt_q;

  // NOTE: default assignment first so every path drives cnt_d; no latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !full_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lenet_seq_ctrl.sv
// -----------------------------------------------------------------------------
// lenet_seq_ctrl
// Sequencer between an AXI4-Lite register decode and a LeNet inference core.
// Register writes stream weights, biases and feature-map words into three
// buffers (streams may interleave); once all three are full the core is
// started, and its result is latched for readback.
//   ACLK, ARESET              : clock, synchronous active-high reset
//   reg_we/reg_addr/reg_wdata : one-cycle register write from the slave decode
//   w_*/b_*/f_*               : weight / bias / fmap buffer write ports
//   core_start, core_rst      : one-cycle start and soft-reset pulses to core
//   core_done, core_result    : completion pulse and class index from core
//   stat_done, stat_result    : latched completion flag and class index
//   stat_err                  : sticky flag for dropped data writes
//   stat_state                : current state encoding
// -----------------------------------------------------------------------------
module lenet_seq_ctrl
  import lenet_pkg::*;
#(
  parameter int unsigned N_WEIGHT = N_WEIGHT_DEF,
  parameter int unsigned N_BIAS   = N_BIAS_DEF,
  parameter int unsigned N_FMAP   = N_FMAP_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                reg_we,
  input  logic [4:0]          reg_addr,
  input  logic [DATA_W-1:0]   reg_wdata,
  output logic                w_we,
  output logic [W_ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0]   w_data,
  output logic                b_we,
  output logic [B_ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0]   b_data,
  output logic                f_we,
  output logic [F_ADDR_W-1:0] f_addr,
  output logic [DATA_W-1:0]   f_data,
  output logic                core_start,
  output logic                core_rst,
  input  logic                core_done,
  input  logic [3:0]          core_result,
  output logic                stat_done,
  output logic [3:0]          stat_result,
  output logic                stat_err,
  output logic [1:0]          stat_state
);

  state_e state_q;

  logic                w_we_q, b_we_q, f_we_q;
  logic [W_ADDR_W-1:0] w_addr_q;
  logic [B_ADDR_W-1:0] b_addr_q;
  logic [F_ADDR_W-1:0] f_addr_q;
  logic [DATA_W-1:0]   w_data_q, b_data_q, f_data_q;
  logic                core_start_q, core_rst_q;
  logic                stat_done_q, stat_err_q;
  logic [3:0]          stat_result_q;

  logic [W_ADDR_W-1:0] w_cnt;
  logic [B_ADDR_W-1:0] b_cnt;
  logic [F_ADDR_W-1:0] f_cnt;
  logic                w_full, b_full, f_full, all_full;

  // Write decode
  logic ctrl_wr, w_wr, b_wr, f_wr;
  logic start_cmd, stop_cmd, soft_clr;
  logic w_inc, b_inc, f_inc, cnt_clr, data_drop;

  assign ctrl_wr   = reg_we && (reg_addr == REG_CTRL);
  assign w_wr      = reg_we && (reg_addr == REG_WEIGHT);
  assign b_wr      = reg_we && (reg_addr == REG_BIAS);
  assign f_wr      = reg_we && (reg_addr == REG_FMAP);
  assign soft_clr  = reg_we && (reg_addr == REG_CLEAR) && reg_wdata[0];
  assign start_cmd = ctrl_wr && reg_wdata[0];
  assign stop_cmd  = ctrl_wr && !reg_wdata[0];

  // A data word is accepted only while loading and while its stream has room.
  assign w_inc     = (state_q == ST_LOAD) && w_wr && !w_full;
  assign b_inc     = (state_q == ST_LOAD) && b_wr && !b_full;
  assign f_inc     = (state_q == ST_LOAD) && f_wr && !f_full;
  assign data_drop = (w_wr || b_wr || f_wr) && !(w_inc || b_inc || f_inc);
  assign cnt_clr   = soft_clr || (start_cmd && (state_q == ST_IDLE));
  assign all_full  = w_full && b_full && f_full;

  lenet_load_cnt #(.LIMIT(N_WEIGHT), .CNT_W(W_ADDR_W)) u_w_cnt (
    .clk_i(ACLK), .rst_i(ARESET), .clr_i(cnt_clr), .inc_i(w_inc),
    .cnt_o(w_cnt), .full_o(w_full)
  );

  lenet_load_cnt #(.LIMIT(N_BIAS), .CNT_W(B_ADDR_W)) u_b_cnt (
    .clk_i(ACLK), .rst_i(ARESET), .clr_i(cnt_clr), .inc_i(b_inc),
    .cnt_o(b_cnt), .full_o(b_full)
  );

  lenet_load_cnt #(.LIMIT(N_FMAP), .CNT_W(F_ADDR_W)) u_f_cnt (
    .clk_i(ACLK), .rst_i(ARESET), .clr_i(cnt_clr), .inc_i(f_inc),
    .cnt_o(f_cnt), .full_o(f_full)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q       <= ST_IDLE;
      w_we_q        <= 1'b0;
      b_we_q        <= 1'b0;
      f_we_q        <= 1'b0;
      w_addr_q      <= '0;
      b_addr_q      <= '0;
      f_addr_q      <= '0;
      w_data_q      <= '0;
      b_data_q      <= '0;
      f_data_q      <= '0;
      core_start_q  <= 1'b0;
      core_rst_q    <= 1'b0;
      stat_done_q   <= 1'b0;
      stat_result_q <= '0;
      stat_err_q    <= 1'b0;
    end else begin
      // Buffer write ports: one-cycle strobe, address/data held in between.
      w_we_q       <= w_inc;
      b_we_q       <= b_inc;
      f_we_q       <= f_inc;
      core_start_q <= 1'b0;
      core_rst_q   <= 1'b0;
      if (w_inc) begin
        w_addr_q <= w_cnt;
        w_data_q <= reg_wdata;
      end
      if (b_inc) begin
        b_addr_q <= b_cnt;
        b_data_q <= reg_wdata;
      end
      if (f_inc) begin
        f_addr_q <= f_cnt;
        f_data_q <= reg_wdata;
      end

      if (soft_clr) begin
        // Soft clear overrides everything, including a same-cycle core_done.
        state_q       <= ST_IDLE;
        core_rst_q    <= 1'b1;
        stat_done_q   <= 1'b0;
        stat_result_q <= '0;
        stat_err_q    <= 1'b0;
      end else begin
        if (data_drop) begin
          stat_err_q <= 1'b1;
        end
        case (state_q)
          ST_IDLE: begin
            if (start_cmd) state_q <= ST_LOAD;
          end
          ST_LOAD: begin
            // all_full is seen the cycle after the last word was counted, so
            // core_start trails the final buffer write strobe.
            if (stop_cmd) begin
              state_q <= ST_IDLE;
            end else if (all_full) begin
              state_q      <= ST_RUN;
              core_start_q <= 1'b1;
            end
          end
          ST_RUN: begin
            if (stop_cmd) begin
              state_q <= ST_IDLE;
            end else if (core_done) begin
              stat_result_q <= core_result;
              stat_done_q   <= 1'b1;
              state_q       <= ST_DONE;
            end
          end
          ST_DONE: begin
            if (stop_cmd) begin
              stat_done_q <= 1'b0;
              state_q     <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign w_we        = w_we_q;
  assign w_addr      = w_addr_q;
  assign w_data      = w_data_q;
  assign b_we        = b_we_q;
  assign b_addr      = b_addr_q;
  assign b_data      = b_data_q;
  assign f_we        = f_we_q;
  assign f_addr      = f_addr_q;
  assign f_data      = f_data_q;
  assign core_start  = core_start_q;
  assign core_rst    = core_rst_q;
  assign stat_done   = stat_done_q;
  assign stat_result = stat_result_q;
  assign stat_err    = stat_err_q;
  assign stat_state  = state_q;

endmodule
